// File: rtl/mem_arbiter.sv
// Two-requester arbiter/sequencer for a single-port data memory.
// Grants one port at a time, drives the memory pins for WAIT_CYC+1 access
// cycles, captures read data and returns a one-cycle ack to the owner.
module mem_arbiter #(
  parameter int unsigned ADDR_LINE = 8,
  parameter int unsigned D_SIZE    = 32,
  parameter int unsigned WAIT_CYC  = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0,
  input  logic                 rw0,
  input  logic [ADDR_LINE-1:0] addr0,
  input  logic [D_SIZE-1:0]    wdata0,
  output logic                 ack0,
  output logic [D_SIZE-1:0]    rdata0,
  input  logic                 req1,
  input  logic                 rw1,
  input  logic [ADDR_LINE-1:0] addr1,
  input  logic [D_SIZE-1:0]    wdata1,
  output logic                 ack1,
  output logic [D_SIZE-1:0]    rdata1,
  output logic                 mem_update,
  output logic                 mem_rw,
  output logic [ADDR_LINE-1:0] mem_addr,
  output logic [D_SIZE-1:0]    mem_wdata,
  input  logic [D_SIZE-1:0]    mem_rdata,
  output logic                 busy,
  output logic                 grant_id
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]     cnt, cnt_next;
  logic                 last_grant, last_next;
  logic                 owner, owner_next;
  logic                 op_rw, op_rw_next;
  logic [ADDR_LINE-1:0] op_addr, op_addr_next;
  logic [D_SIZE-1:0]    op_wdata, op_wdata_next;

  logic                 grant_id_next;
  logic                 ack0_next, ack1_next;
  logic [D_SIZE-1:0]    rdata0_next, rdata1_next;
  logic                 mem_update_next, mem_rw_next;
  logic [ADDR_LINE-1:0] mem_addr_next;
  logic [D_SIZE-1:0]    mem_wdata_next;
  logic                 busy_next;

  logic                 grant_valid;
  logic                 grant_sel;
  logic                 sel_rw;
  logic [ADDR_LINE-1:0] sel_addr;
  logic [D_SIZE-1:0]    sel_wdata;

  // Round-robin pick: on a tie the port that did not win last time goes first.
  assign grant_valid = req0 | req1;
  assign grant_sel   = (req0 & req1) ? ~last_grant : req1;
  assign sel_rw      = grant_sel ? rw1    : rw0;
  assign sel_addr    = grant_sel ? addr1  : addr0;
  assign sel_wdata   = grant_sel ? wdata1 : wdata0;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = ACCESS;
      ACCESS:  if (cnt == '0)   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the datapath and of every registered output.
  always_comb begin
    cnt_next        = cnt;
    last_next       = last_grant;
    owner_next      = owner;
    op_rw_next      = op_rw;
    op_addr_next    = op_addr;
    op_wdata_next   = op_wdata;
    grant_id_next   = grant_id;
    rdata0_next     = rdata0;
    rdata1_next     = rdata1;
    ack0_next       = 1'b0;
    ack1_next       = 1'b0;
    mem_update_next = 1'b0;
    mem_rw_next     = 1'b0;
    mem_addr_next   = '0;
    mem_wdata_next  = '0;
    busy_next       = 1'b0;
    case (state)
      IDLE: begin
        if (grant_valid) begin
          owner_next      = grant_sel;
          op_rw_next      = sel_rw;
          op_addr_next    = sel_addr;
          op_wdata_next   = sel_wdata;
          grant_id_next   = grant_sel;
          cnt_next        = CNT_W'(WAIT_CYC);
          busy_next       = 1'b1;
          mem_rw_next     = sel_rw;
          mem_addr_next   = sel_addr;
          mem_wdata_next  = sel_wdata;
          mem_update_next = (CNT_W'(WAIT_CYC) == '0) & sel_rw;
        end
      end
      ACCESS: begin
        busy_next = 1'b1;
        if (cnt != '0) begin
          cnt_next        = cnt - CNT_W'(1);
          mem_rw_next     = op_rw;
          mem_addr_next   = op_addr;
          mem_wdata_next  = op_wdata;
          mem_update_next = (cnt == CNT_W'(1)) & op_rw;
        end else begin
          if (!op_rw) begin
            if (owner) rdata1_next = mem_rdata;
            else       rdata0_next = mem_rdata;
          end
          ack0_next = ~owner;
          ack1_next = owner;
        end
      end
      DONE: begin
        last_next = owner;
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      op_rw      <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= '0;
      grant_id   <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      mem_update <= 1'b0;
      mem_rw     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      cnt        <= cnt_next;
      last_grant <= last_next;
      owner      <= owner_next;
      op_rw      <= op_rw_next;
      op_addr    <= op_addr_next;
      op_wdata   <= op_wdata_next;
      grant_id   <= grant_id_next;
      ack0       <= ack0_next;
      ack1       <= ack1_next;
      rdata0     <= rdata0_next;
      rdata1     <= rdata1_next;
      mem_update <= mem_update_next;
      mem_rw     <= mem_rw_next;
      mem_addr   <= mem_addr_next;
      mem_wdata  <= mem_wdata_next;
      busy       <= busy_next;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (WAIT_CYC = 1, 0, 15), each with its
// own memory, checked every cycle against a transaction-timing model.
module tb_mem_arbiter;

  localparam int unsigned AW = 8;
  localparam int unsigned DW = 32;
  localparam int NI = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;

  logic          req0_s [NI];
  logic          rw0_s  [NI];
  logic [AW-1:0] addr0_s [NI];
  logic [DW-1:0] wdata0_s [NI];
  logic          req1_s [NI];
  logic          rw1_s  [NI];
  logic [AW-1:0] addr1_s [NI];
  logic [DW-1:0] wdata1_s [NI];

  logic          d_ack0 [NI];
  logic          d_ack1 [NI];
  logic [DW-1:0] d_rd0 [NI];
  logic [DW-1:0] d_rd1 [NI];
  logic          d_upd [NI];
  logic          d_mrw [NI];
  logic [AW-1:0] d_maddr [NI];
  logic [DW-1:0] d_mwd [NI];
  logic          d_busy [NI];
  logic          d_gid [NI];

  int n_checks = 0;
  int n_pass   = 0;
  int unsigned edge_cnt = 0;

  // model state
  bit            m_init = 1'b0;
  bit            m_act [NI];
  logic          m_own [NI];
  logic          m_rw [NI];
  logic          m_last [NI];
  logic          m_gid [NI];
  logic [AW-1:0] m_addr [NI];
  logic [DW-1:0] m_wd [NI];
  logic [DW-1:0] m_rd0 [NI];
  logic [DW-1:0] m_rd1 [NI];
  int unsigned   m_start [NI];
  logic [DW-1:0] m_mem [NI][256];

  always #5 clk = ~clk;

  function automatic int unsigned wc(input int i);
    if (i == 0) return 32'd1;
    if (i == 1) return 32'd0;
    return 32'd15;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned W = (g == 0) ? 32'd1 : ((g == 1) ? 32'd0 : 32'd15);
    logic [DW-1:0] mem [256];
    logic [DW-1:0] mem_rd;
    bit inited = 1'b0;

    assign mem_rd = mem[d_maddr[g]];

    // Memory: combinational read, write committed on the edge mem_update is high.
    always @(posedge clk) begin
      if (!inited) begin
        for (int k = 0; k < 256; k++) mem[k] <= '0;
        inited <= 1'b1;
      end else if (d_upd[g] && d_mrw[g]) begin
        mem[d_maddr[g]] <= d_mwd[g];
      end
    end

    mem_arbiter #(.ADDR_LINE(AW), .D_SIZE(DW), .WAIT_CYC(W)) u_dut (
      .clk(clk), .reset(reset),
      .req0(req0_s[g]), .rw0(rw0_s[g]), .addr0(addr0_s[g]), .wdata0(wdata0_s[g]),
      .ack0(d_ack0[g]), .rdata0(d_rd0[g]),
      .req1(req1_s[g]), .rw1(rw1_s[g]), .addr1(addr1_s[g]), .wdata1(wdata1_s[g]),
      .ack1(d_ack1[g]), .rdata1(d_rd1[g]),
      .mem_update(d_upd[g]), .mem_rw(d_mrw[g]), .mem_addr(d_maddr[g]),
      .mem_wdata(d_mwd[g]), .mem_rdata(mem_rd),
      .busy(d_busy[g]), .grant_id(d_gid[g])
    );
  end

  task automatic check(input string name, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h at t=%0t", name, i, act, exp, $time);
  endtask

  // Transaction model: a grant at edge N owns ACCESS for edges N..N+W,
  // DONE after edge N+W+1, and the arbiter is free again from edge N+W+3.
  initial begin : model
    int unsigned w, e;
    logic p;
    forever begin
      @(posedge clk);
      edge_cnt++;
      e = edge_cnt;
      if (!m_init) begin
        for (int i = 0; i < NI; i++)
          for (int k = 0; k < 256; k++) m_mem[i][k] = '0;
        m_init = 1'b1;
      end
      for (int i = 0; i < NI; i++) begin
        w = wc(i);
        if (!reset) begin
          m_act[i] = 1'b0; m_last[i] = 1'b1; m_gid[i] = 1'b0;
          m_rd0[i] = '0;   m_rd1[i] = '0;
        end else if (m_act[i]) begin
          if (e == m_start[i] + w + 1) begin
            if (m_rw[i])      m_mem[i][m_addr[i]] = m_wd[i];
            else if (m_own[i]) m_rd1[i] = m_mem[i][m_addr[i]];
            else               m_rd0[i] = m_mem[i][m_addr[i]];
          end
          if (e == m_start[i] + w + 2) begin
            m_last[i] = m_own[i];
            m_act[i]  = 1'b0;
          end
        end else if (req0_s[i] || req1_s[i]) begin
          p = (req0_s[i] && req1_s[i]) ? ~m_last[i] : req1_s[i];
          m_own[i]   = p;
          m_gid[i]   = p;
          m_rw[i]    = p ? rw1_s[i] : rw0_s[i];
          m_addr[i]  = p ? addr1_s[i] : addr0_s[i];
          m_wd[i]    = p ? wdata1_s[i] : wdata0_s[i];
          m_start[i] = e;
          m_act[i]   = 1'b1;
        end
      end
    end
  end

  // Compare every output of every instance against the model on each negedge.
  initial begin : compare
    int unsigned w, e;
    logic acc, done;
    logic e_upd, e_rw, e_ack0, e_ack1, e_busy, e_gid;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wd, e_rd0, e_rd1;
    forever begin
      @(negedge clk);
      e = edge_cnt;
      for (int i = 0; i < NI; i++) begin
        w = wc(i);
        if (!reset) begin
          acc = 1'b0; done = 1'b0; e_gid = 1'b0; e_rd0 = '0; e_rd1 = '0;
          e_rw = 1'b0; e_addr = '0; e_wd = '0;
        end else begin
          acc   = m_act[i] && (e >= m_start[i]) && (e <= m_start[i] + w);
          done  = m_act[i] && (e == m_start[i] + w + 1);
          e_gid = m_gid[i];
          e_rd0 = m_rd0[i];
          e_rd1 = m_rd1[i];
          e_rw   = acc ? m_rw[i] : 1'b0;
          e_addr = acc ? m_addr[i] : '0;
          e_wd   = acc ? m_wd[i] : '0;
        end
        e_upd  = acc && (e == m_start[i] + w) && m_rw[i];
        e_ack0 = done && !m_own[i];
        e_ack1 = done && m_own[i];
        e_busy = acc || done;
        check("ack0", i, 32'(d_ack0[i]), 32'(e_ack0));
        check("ack1", i, 32'(d_ack1[i]), 32'(e_ack1));
        check("ack_excl", i, 32'(!(d_ack0[i] && d_ack1[i])), 32'd1);
        check("rdata0", i, d_rd0[i], e_rd0);
        check("rdata1", i, d_rd1[i], e_rd1);
        check("mem_update", i, 32'(d_upd[i]), 32'(e_upd));
        check("mem_rw", i, 32'(d_mrw[i]), 32'(e_rw));
        check("mem_addr", i, 32'(d_maddr[i]), 32'(e_addr));
        check("mem_wdata", i, d_mwd[i], e_wd);
        check("busy", i, 32'(d_busy[i]), 32'(e_busy));
        check("grant_id", i, 32'(d_gid[i]), 32'(e_gid));
      end
    end
  end

  task automatic drive(input int i, input bit p, input logic req, input logic rw,
                       input logic [AW-1:0] a, input logic [DW-1:0] wd);
    if (!p) begin
      req0_s[i] = req; rw0_s[i] = rw; addr0_s[i] = a; wdata0_s[i] = wd;
    end else begin
      req1_s[i] = req; rw1_s[i] = rw; addr1_s[i] = a; wdata1_s[i] = wd;
    end
  endtask

  // Wait (bounded) for the ack of port p, count mem_update pulses, then drop req.
  task automatic wait_ack(input int i, input bit p, input int unsigned e0,
                          output int lat, output int nupd);
    lat = -1;
    nupd = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (d_upd[i]) nupd++;
      if (p ? d_ack1[i] : d_ack0[i]) begin
        lat = int'(edge_cnt - e0);
        break;
      end
    end
    drive(i, p, 1'b0, 1'b0, '0, '0);
    check("ack_seen", i, 32'(lat >= 0), 32'd1);
  endtask

  // One transaction from an idle arbiter; returns latency from the request edge.
  task automatic run_txn(input int i, input bit p, input logic rw, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, output int lat, output int nupd);
    int unsigned e0;
    drive(i, p, 1'b1, rw, a, wd);
    e0 = edge_cnt;
    wait_ack(i, p, e0, lat, nupd);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat, nupd, n, nack;
    int seq [4];
    for (int i = 0; i < NI; i++) begin
      drive(i, 1'b0, 1'b0, 1'b0, '0, '0);
      drive(i, 1'b1, 1'b0, 1'b0, '0, '0);
    end
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 0, 32'(d_busy[0]), 32'd0);
    check("rst_gid", 0, 32'(d_gid[0]), 32'd0);
    check("rst_rdata0", 0, d_rd0[0], 32'd0);
    check("rst_maddr", 0, 32'(d_maddr[0]), 32'd0);
    @(posedge clk); #1 reset = 1'b1;

    // 1: write then read back on port 0
    run_txn(0, 1'b0, 1'b1, 8'd3, 32'h0000_00A5, lat, nupd);
    check("t1_wr_lat", 0, 32'(lat), 32'd3);
    check("t1_wr_upd", 0, 32'(nupd), 32'd1);
    run_txn(0, 1'b0, 1'b0, 8'd3, 32'h0, lat, nupd);
    check("t1_rd_lat", 0, 32'(lat), 32'd3);
    check("t1_rd_upd", 0, 32'(nupd), 32'd0);
    check("t1_rdata0", 0, d_rd0[0], 32'h0000_00A5);

    // 2: both ports held -> strict alternation starting with port 0
    do_reset();
    drive(0, 1'b0, 1'b1, 1'b0, 8'd3, '0);
    drive(0, 1'b1, 1'b1, 1'b0, 8'd4, '0);
    n = 0;
    for (int k = 0; k < 4; k++) seq[k] = 9;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (d_ack0[0]) begin seq[n] = 0; n++; end
      else if (d_ack1[0]) begin seq[n] = 1; n++; end
      if (n == 4) break;
    end
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    drive(0, 1'b1, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    check("t2_nack", 0, 32'(n), 32'd4);
    check("t2_seq0", 0, 32'(seq[0]), 32'd0);
    check("t2_seq1", 0, 32'(seq[1]), 32'd1);
    check("t2_seq2", 0, 32'(seq[2]), 32'd0);
    check("t2_seq3", 0, 32'(seq[3]), 32'd1);
    check("t2_rdata0", 0, d_rd0[0], 32'h0000_00A5);

    // 3: port 1 write queued behind a port 0 read of the same address
    run_txn(0, 1'b0, 1'b1, 8'd5, 32'h0000_5555, lat, nupd);
    drive(0, 1'b0, 1'b1, 1'b0, 8'd5, '0);
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b1, 1'b1, 8'd5, 32'h0000_1234);
    wait_ack(0, 1'b0, edge_cnt, lat, nupd);
    check("t3_old", 0, d_rd0[0], 32'h0000_5555);
    wait_ack(0, 1'b1, edge_cnt, lat, nupd);
    check("t3_wr_upd", 0, 32'(nupd), 32'd1);
    @(posedge clk); #1;
    run_txn(0, 1'b0, 1'b0, 8'd5, 32'h0, lat, nupd);
    check("t3_new", 0, d_rd0[0], 32'h0000_1234);

    // 4: reset during ACCESS of a write aborts it
    drive(0, 1'b0, 1'b1, 1'b1, 8'd7, 32'h0000_00FF);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("t4_busy", 0, 32'(d_busy[0]), 32'd0);
    check("t4_upd", 0, 32'(d_upd[0]), 32'd0);
    check("t4_ack0", 0, 32'(d_ack0[0]), 32'd0);
    check("t4_maddr", 0, 32'(d_maddr[0]), 32'd0);
    check("t4_rdata0", 0, d_rd0[0], 32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_txn(0, 1'b0, 1'b0, 8'd7, 32'h0, lat, nupd);
    check("t4_rd7", 0, d_rd0[0], 32'd0);

    // 5: latency at the wait-count extremes
    run_txn(1, 1'b0, 1'b1, 8'h10, 32'hDEAD_BEEF, lat, nupd);
    check("t5_w0_wr_lat", 1, 32'(lat), 32'd2);
    check("t5_w0_wr_upd", 1, 32'(nupd), 32'd1);
    run_txn(1, 1'b0, 1'b0, 8'h10, 32'h0, lat, nupd);
    check("t5_w0_rd_lat", 1, 32'(lat), 32'd2);
    check("t5_w0_rdata0", 1, d_rd0[1], 32'hDEAD_BEEF);
    run_txn(2, 1'b1, 1'b1, 8'h20, 32'hCAFE_F00D, lat, nupd);
    check("t5_w15_wr_lat", 2, 32'(lat), 32'd17);
    check("t5_w15_wr_upd", 2, 32'(nupd), 32'd1);
    run_txn(2, 1'b1, 1'b0, 8'h20, 32'h0, lat, nupd);
    check("t5_w15_rd_lat", 2, 32'(lat), 32'd17);
    check("t5_w15_rdata1", 2, d_rd1[2], 32'hCAFE_F00D);

    // 6: port 1 drops req one cycle after grant
    drive(0, 1'b1, 1'b1, 1'b0, 8'd9, '0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive(0, 1'b1, 1'b0, 1'b0, '0, '0);
    nack = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (d_ack1[0]) nack++;
    end
    check("t6_nack1", 0, 32'(nack), 32'd1);
    check("t6_busy", 0, 32'(d_busy[0]), 32'd0);
    check("t6_gid", 0, 32'(d_gid[0]), 32'd1);

    @(posedge clk); #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
